// File: rtl/wb_master_port.sv
// Single-outstanding classic Wishbone master: one valid/ready request becomes one bus cycle,
// and the result comes back on a valid/ready response channel (read data, error, timeout).
module wb_master_port #(
  parameter int ADR_WIDTH = 16,
  parameter int DAT_WIDTH = 64,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [ADR_WIDTH-1:0] req_adr_i,
  input  logic [DAT_WIDTH-1:0] req_dat_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DAT_WIDTH-1:0] rsp_dat_o,
  output logic                 rsp_err_o,
  output logic                 rsp_timeout_o,
  output logic [ADR_WIDTH-1:0] adr_o,
  output logic [DAT_WIDTH-1:0] dat_o,
  input  logic [DAT_WIDTH-1:0] dat_i,
  output logic                 we_o,
  output logic                 stb_o,
  output logic                 cyc_o,
  input  logic                 ack_i,
  input  logic                 err_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // A 1-bit counter is kept when the timeout is disabled so the width never collapses to 0.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  state_e               state_q;
  logic [ADR_WIDTH-1:0] adr_q;
  logic [DAT_WIDTH-1:0] dat_q;
  logic                 we_q;
  logic                 stb_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 rsp_valid_q;
  logic [DAT_WIDTH-1:0] rsp_dat_q;
  logic                 rsp_err_q;
  logic                 rsp_timeout_q;

  logic [CNT_W-1:0]     cnt_d;
  logic [DAT_WIDTH-1:0] ack_dat_d;
  logic                 timeout_hit;

  assign cnt_d       = cnt_sat_inc(cnt_q);
  assign ack_dat_d   = we_q ? '0 : dat_i;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q       <= S_IDLE;
      adr_q         <= '0;
      dat_q         <= '0;
      we_q          <= 1'b0;
      stb_q         <= 1'b0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_dat_q     <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            adr_q   <= req_adr_i;
            dat_q   <= req_dat_i;
            we_q    <= req_we_i;
            stb_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_BUS;
          end
        end
        // err_i wins over ack_i; the bus strobe drops on the same edge the response is captured.
        S_BUS: begin
          if (err_i) begin
            rsp_dat_q     <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            stb_q         <= 1'b0;
            state_q       <= S_RESP;
          end else if (ack_i) begin
            rsp_dat_q     <= ack_dat_d;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            stb_q         <= 1'b0;
            state_q       <= S_RESP;
          end else if (timeout_hit) begin
            rsp_dat_q     <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            stb_q         <= 1'b0;
            state_q       <= S_RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          stb_q       <= 1'b0;
          rsp_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o   = (state_q == S_IDLE) && rst_i;
  assign adr_o         = adr_q;
  assign dat_o         = dat_q;
  assign we_o          = we_q;
  assign stb_o         = stb_q;
  assign cyc_o         = stb_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_dat_o     = rsp_dat_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule
